parity_frame_ctrl: RTL and testbench

//   Sequencer for the XOR parity datapath: accepts a parallel word over a valid/ready

---
 rtl/parity_frame_ctrl.sv | 133 +++++++++++++
 tb/tb_parity_frame_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_ctrl.sv
// parity_frame_ctrl: takes a word over valid/ready, streams it one bit per beat, then appends an XOR parity beat.
// Build option: define PARITY_ODD_EN for odd parity (default build uses even parity).
module parity_frame_ctrl #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             parity_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] data_reg;
    logic [CW-1:0]    cnt;
    logic             acc;
    logic [CW-1:0]    bit_idx;
    logic             par_bit;

    assign bit_idx = MSB_FIRST ? (LAST_IDX - cnt) : cnt;

`ifdef PARITY_ODD_EN
    assign par_bit = ~acc;
`else
    assign par_bit = acc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Serial outputs are decoded from registered state only, so ser_ready never reaches them.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        ser_valid  = 1'b0;
        ser_out    = 1'b0;
        ser_last   = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                ser_valid = 1'b1;
                ser_out   = data_reg[bit_idx];
                if (ser_ready && (cnt == LAST_IDX)) begin
                    next_state = PAR;
                end
            end
            PAR: begin
                ser_valid = 1'b1;
                ser_last  = 1'b1;
                ser_out   = par_bit;
                if (ser_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg   <= '0;
            cnt        <= '0;
            acc        <= 1'b0;
            parity_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_reg <= in_data;
                        cnt      <= '0;
                        acc      <= 1'b0;
                    end
                end
                DATA: begin
                    if (ser_ready) begin
                        acc <= acc ^ ser_out;
                        // The parity beat covers the cnt==WIDTH case, so the counter wraps instead.
                        if (cnt == LAST_IDX) begin
                            cnt <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                PAR: begin
                    if (ser_ready) begin
                        parity_out <= ser_out;
                        done       <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench for parity_frame_ctrl: an LSB-first and an MSB-first instance share stimulus,
// and every frame is compared against a ones-count parity model.
`timescale 1ns/1ps
module tb_parity_frame_ctrl;

`ifdef PARITY_ODD_EN
    localparam bit ODD = 1'b1;
`else
    localparam bit ODD = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic [7:0] in_data   = 8'h00;
    logic       in_valid  = 1'b0;
    logic       ser_ready = 1'b0;

    logic in_ready, ser_out, ser_valid, ser_last, parity_out, busy, done;
    logic m_in_ready, m_ser_out, m_ser_valid, m_ser_last, m_parity_out, m_busy, m_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] got_lsb, got_msb, got_last;
    int         nbeats, done_count, stall_changes, ready_violations;
    bit         timed_out;

    always #5 clk = ~clk;

    parity_frame_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last),
        .parity_out(parity_out), .busy(busy), .done(done)
    );

    parity_frame_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(m_in_ready),
        .ser_out(m_ser_out), .ser_valid(m_ser_valid), .ser_ready(ser_ready), .ser_last(m_ser_last),
        .parity_out(m_parity_out), .busy(m_busy), .done(m_done)
    );

    function automatic logic exp_parity(input logic [7:0] w);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(w[i]);
        return logic'((ones % 2) != 0) ^ ODD;
    endfunction

    // Beat i of the frame lands in bit i; bit 8 is the parity beat.
    function automatic logic [8:0] exp_frame(input logic [7:0] w, input bit msb);
        logic [8:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i] = msb ? w[7 - i] : w[i];
        f[8] = exp_parity(w);
        return f;
    endfunction

    task automatic run_frame(input logic [7:0] w, input int stall_pct, input bit fixed_stall, input bit noisy_in);
        int   cyc;
        int   stall_left;
        int   stalled_at;
        bit   got_end;
        bit   prev_stalled;
        logic prev_out;
        logic prev_msb;
        got_lsb = '0; got_msb = '0; got_last = '0;
        nbeats = 0; done_count = 0; stall_changes = 0; ready_violations = 0; timed_out = 1'b0;
        @(negedge clk);
        in_data = w; in_valid = 1'b1; ser_ready = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!in_ready) timed_out = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'($urandom);
        got_end = 1'b0; prev_stalled = 1'b0; stall_left = 0; stalled_at = -1;
        prev_out = 1'b0; prev_msb = 1'b0; cyc = 0;
        while (!got_end && cyc < 300) begin
            if (done) done_count++;
            if (in_ready) ready_violations++;
            if (prev_stalled && (ser_out !== prev_out || m_ser_out !== prev_msb)) stall_changes++;
            if (fixed_stall && (nbeats == 4 || nbeats == 8) && stalled_at != nbeats) begin
                stalled_at = nbeats;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                ser_ready = 1'b0;
                stall_left--;
            end else begin
                ser_ready = (int'($urandom_range(99)) >= stall_pct);
            end
            if (noisy_in) begin
                in_valid = 1'($urandom_range(1));
                in_data  = 8'($urandom);
            end
            if (ser_valid && ser_ready) begin
                if (nbeats < 9) begin
                    got_lsb[4'(nbeats)]  = ser_out;
                    got_msb[4'(nbeats)]  = m_ser_out;
                    got_last[4'(nbeats)] = ser_last;
                end
                nbeats++;
                got_end = ser_last;
                prev_stalled = 1'b0;
            end else begin
                prev_stalled = ser_valid;
                prev_out = ser_out;
                prev_msb = m_ser_out;
            end
            @(negedge clk);
            cyc++;
        end
        if (!got_end) timed_out = 1'b1;
        in_valid = 1'b0; ser_ready = 1'b0;
        repeat (2) begin
            if (done) done_count++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        #1 rst_n = 1'b0;
        #2;
        obs = {in_ready, ser_valid, ser_out, ser_last, busy, done, parity_out,
               m_in_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy, m_done, m_parity_out};
        n_checks++;
        if (obs !== 14'b1000000_1000000) $display("[TB] FAIL reset_outputs: got %b expected %b", obs, 14'b1000000_1000000);
        else n_pass++;
        in_valid = 1'b1; in_data = 8'hFF;
        repeat (3) @(negedge clk);
        obs = {in_ready, ser_valid, ser_out, ser_last, busy, done, parity_out,
               m_in_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy, m_done, m_parity_out};
        n_checks++;
        if (obs !== 14'b1000000_1000000) $display("[TB] FAIL reset_held: got %b expected %b", obs, 14'b1000000_1000000);
        else n_pass++;
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_known_words();
        logic [7:0] words [2];
        words[0] = 8'hA5;
        words[1] = 8'h07;
        for (int k = 0; k < 2; k++) begin
            run_frame(words[k], 0, 1'b0, 1'b0);
            n_checks++;
            if ({got_last, got_msb, got_lsb} !== {9'h100, exp_frame(words[k], 1'b1), exp_frame(words[k], 1'b0)} || timed_out)
                $display("[TB] FAIL known_beats w=%h: got last=%b msb=%b lsb=%b expected last=%b msb=%b lsb=%b",
                         words[k], got_last, got_msb, got_lsb, 9'h100, exp_frame(words[k], 1'b1), exp_frame(words[k], 1'b0));
            else n_pass++;
            n_checks++;
            if (done_count !== 1) $display("[TB] FAIL known_done w=%h: got %0d pulses expected 1", words[k], done_count);
            else n_pass++;
            n_checks++;
            if ({parity_out, m_parity_out} !== {2{exp_parity(words[k])}})
                $display("[TB] FAIL known_parity_out w=%h: got %b expected %b", words[k], {parity_out, m_parity_out}, {2{exp_parity(words[k])}});
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        run_frame(8'hA5, 0, 1'b1, 1'b0);
        n_checks++;
        if ({got_last, got_lsb} !== {9'h100, exp_frame(8'hA5, 1'b0)} || timed_out)
            $display("[TB] FAIL stall_beats: got last=%b lsb=%b expected last=%b lsb=%b", got_last, got_lsb, 9'h100, exp_frame(8'hA5, 1'b0));
        else n_pass++;
        n_checks++;
        if (stall_changes !== 0) $display("[TB] FAIL stall_hold: got %0d changes expected 0", stall_changes);
        else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("[TB] FAIL stall_done: got %0d pulses expected 1", done_count);
        else n_pass++;
    endtask

    task automatic test_busy_input();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] w;
            w = 8'($urandom);
            run_frame(w, 20, 1'b0, 1'b1);
            n_checks++;
            if (ready_violations !== 0) $display("[TB] FAIL busy_in_ready w=%h: got %0d cycles with in_ready high expected 0", w, ready_violations);
            else n_pass++;
            n_checks++;
            if ({got_last, got_lsb} !== {9'h100, exp_frame(w, 1'b0)} || timed_out)
                $display("[TB] FAIL busy_frame w=%h: got last=%b lsb=%b expected last=%b lsb=%b", w, got_last, got_lsb, 9'h100, exp_frame(w, 1'b0));
            else n_pass++;
        end
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 16; k++) begin
            logic [7:0] w;
            w = 8'($urandom);
            run_frame(w, 40, 1'b0, 1'b0);
            n_checks++;
            if ({got_last, got_msb, got_lsb} !== {9'h100, exp_frame(w, 1'b1), exp_frame(w, 1'b0)} || timed_out || stall_changes != 0)
                $display("[TB] FAIL random_frame w=%h: got last=%b msb=%b lsb=%b stall_changes=%0d expected last=%b msb=%b lsb=%b",
                         w, got_last, got_msb, got_lsb, stall_changes, 9'h100, exp_frame(w, 1'b1), exp_frame(w, 1'b0));
            else n_pass++;
            n_checks++;
            if (done_count !== 1 || parity_out !== exp_parity(w))
                $display("[TB] FAIL random_done w=%h: got pulses=%0d parity_out=%b expected 1 and %b", w, done_count, parity_out, exp_parity(w));
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] busy_trace, done_trace;
        logic [8:0]  f1, f2;
        logic        p1, p2;
        busy_trace = '0; done_trace = '0; f1 = '0; f2 = '0; p1 = 1'b0;
        @(negedge clk);
        in_data = 8'hFF; in_valid = 1'b1; ser_ready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            busy_trace[5'(c)] = busy;
            done_trace[5'(c)] = done;
            if (c >= 1 && c <= 9) f1[4'(c - 1)] = ser_out;
            if (c >= 11 && c <= 19) f2[4'(c - 11)] = ser_out;
            if (c == 10) p1 = parity_out;
            if (c == 1) in_data = 8'h01;
            if (c == 11) in_valid = 1'b0;
            @(negedge clk);
        end
        p2 = parity_out;
        ser_ready = 1'b0;
        n_checks++;
        if (busy_trace !== 21'h0FFBFE) $display("[TB] FAIL b2b_busy_trace: got %h expected %h", busy_trace, 21'h0FFBFE);
        else n_pass++;
        n_checks++;
        if (done_trace !== 21'h100400) $display("[TB] FAIL b2b_done_trace: got %h expected %h", done_trace, 21'h100400);
        else n_pass++;
        n_checks++;
        if ({f2, f1} !== {exp_frame(8'h01, 1'b0), exp_frame(8'hFF, 1'b0)})
            $display("[TB] FAIL b2b_beats: got %b %b expected %b %b", f2, f1, exp_frame(8'h01, 1'b0), exp_frame(8'hFF, 1'b0));
        else n_pass++;
        n_checks++;
        if ({p1, p2} !== {exp_parity(8'hFF), exp_parity(8'h01)})
            $display("[TB] FAIL b2b_parity_out: got %b expected %b", {p1, p2}, {exp_parity(8'hFF), exp_parity(8'h01)});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [13:0] obs;
        int          done_seen;
        @(negedge clk);
        in_data = 8'hA5; in_valid = 1'b1; ser_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL midframe_busy: got %b expected 1", busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        obs = {in_ready, ser_valid, ser_out, ser_last, busy, done, parity_out,
               m_in_ready, m_ser_valid, m_ser_out, m_ser_last, m_busy, m_done, m_parity_out};
        n_checks++;
        if (obs !== 14'b1000000_1000000) $display("[TB] FAIL abort_outputs: got %b expected %b", obs, 14'b1000000_1000000);
        else n_pass++;
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        n_checks++;
        if (done_seen !== 0) $display("[TB] FAIL abort_done: got %0d pulses expected 0", done_seen);
        else n_pass++;
        ser_ready = 1'b0;
        run_frame(8'h03, 0, 1'b0, 1'b0);
        n_checks++;
        if ({got_last, got_msb, got_lsb} !== {9'h100, exp_frame(8'h03, 1'b1), exp_frame(8'h03, 1'b0)} || timed_out)
            $display("[TB] FAIL post_reset_beats: got last=%b msb=%b lsb=%b expected last=%b msb=%b lsb=%b",
                     got_last, got_msb, got_lsb, 9'h100, exp_frame(8'h03, 1'b1), exp_frame(8'h03, 1'b0));
        else n_pass++;
        n_checks++;
        if (done_count !== 1 || parity_out !== exp_parity(8'h03))
            $display("[TB] FAIL post_reset_done: got pulses=%0d parity_out=%b expected 1 and %b", done_count, parity_out, exp_parity(8'h03));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_known_words();
        test_stall();
        test_busy_input();
        test_random_frames();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
